throttle_rate_sched: RTL and testbench
======================================

// Module: throttle_rate_sched
// PURPOSE
//  Throttle-level scheduler placed between the debounced freq up/down buttons and the slow-clock output.
//  Arbitrates button steps against an external set-point command, then ramps the applied level toward
//  the target one step at a time with a minimum dwell between steps.
//  Each level change commits only at a slow_clk period boundary, so no runt pulses or glitches occur.
// PARAMETERS
//  NUM_LEVELS  6          number of levels; level 0 = stopped, levels 1..NUM_LEVELS-1 = running
//  LEVEL_W     3          width of level buses
//  BASE_HALF   3_125_000  half-period in CLK_50 cycles at top level (8 Hz)
//  STEP_DWELL  25_000_000 minimum cycles from one level commit to the next
//  CNT_W       32         width of the half-period and dwell counters
// PORTS
//  CLK_50      in   1        system clock, 50 MHz
//  reset       in   1        synchronous, active-low reset
//  up_req      in   1        one-cycle pulse: target +1
//  dn_req      in   1        one-cycle pulse: target -1
//  cmd_valid   in   1        external set-point valid
//  cmd_level   in   LEVEL_W  external set-point level
//  cmd_ready   out  1        scheduler accepts a command this cycle
//  target_num  out  LEVEL_W  requested level
//  freq_num    out  LEVEL_W  applied (committed) level
//  slow_clk    out  1        throttled clock, 50% duty
//  tick        out  1        one-cycle pulse in the first cycle slow_clk reads 1
//  busy        out  1        ramp in progress
// BEHAVIOUR
//  Reset (reset=0 at a CLK_50 edge)
//   - freq_num=0, target_num=0, slow_clk=0, tick=0, busy=0.
//   - Half-period counter=0, state=IDLE, dwell counter preset to STEP_DWELL (first step needs no dwell).
//   - Reset overrides every other input, including in mid-ramp and mid-period.
//  Target update (takes effect on the next edge)
//   - A command is accepted when cmd_valid && cmd_ready. It has priority over buttons that cycle.
//   - cmd_level above NUM_LEVELS-1 clamps to NUM_LEVELS-1.
//   - up_req && dn_req in the same cycle: no change.
//   - up_req saturates at NUM_LEVELS-1; dn_req saturates at 0.
//   - Buttons are accepted in every state. A command is accepted only when cmd_ready=1.
//  Handshake
//   - busy = (state!=IDLE) || (freq_num!=target_num).
//   - cmd_ready = !busy.
//  Slow clock
//   - half(k) = BASE_HALF << (NUM_LEVELS-1-k) for k>=1.
//   - Level 0: slow_clk held 0, counter held 0.
//   - Otherwise the counter runs 0..half(k)-1. At half(k)-1, slow_clk toggles and the counter returns to 0.
//  Dwell counter
//   - Cleared at each commit; increments and saturates at STEP_DWELL. dwell_done = (count==STEP_DWELL).
//  FSM
//   - IDLE: freq_num!=target_num -> (dwell_done ? WAIT_EDGE : DWELL).
//   - DWELL: freq_num==target_num -> IDLE; else dwell_done -> WAIT_EDGE.
//   - WAIT_EDGE: freq_num==target_num -> IDLE with no commit; else at the commit point -> commit, then IDLE.
//   - Commit point: freq_num==0, or (slow_clk==1 && counter==half-1), i.e. the falling boundary.
//   - Commit action: freq_num moves one step toward target_num; counter<=0; slow_clk<=0; dwell<=0.
//   - Every committed period is therefore complete.
//  Commit from level 0: the first rising edge of slow_clk follows half(new) cycles after the commit edge.
//  A target change during DWELL or WAIT_EDGE redirects the ramp. Direction is re-evaluated at the commit.
// TESTING  (bench params: BASE_HALF=4, STEP_DWELL=10, NUM_LEVELS=6)
//  1. reset=0 for 3 cycles with up_req pulsing -> freq_num=0, target_num=0, slow_clk=0, busy=0, cmd_ready=1.
//  2. From 0, one up_req pulse -> target_num=1 next cycle; freq_num=1 within 2 more cycles;
//     slow_clk rises 64 cycles after the commit with a tick; period is 128 cycles.
//  3. From level 1, cmd_level=5 accepted -> freq_num steps 2,3,4,5; commits >=10 cycles apart,
//     each on a falling slow_clk boundary; cmd_ready=0 until freq_num=5; no high phase shorter than half(k).
//  4. Saturation and conflict:
//     - at level 5, up_req -> target 5;
//     - at 0, dn_req -> target 0;
//     - up_req+dn_req together -> no change;
//     - cmd_level=7 -> target 5.
//  5. cmd_valid (ready=1) with cmd_level=2 and up_req in the same cycle from 0 -> target_num=2.
//  6. reset=0 during WAIT_EDGE with slow_clk=1 at level 3 -> next edge all outputs 0, state IDLE.

Source files
------------

// File: rtl/throttle_rate_sched.sv
// -----------------------------------------------------------------------------
// throttle_rate_sched
//
// Throttle-level scheduler between the debounced up/down buttons and the
// slow-clock output. Button steps and an external set-point command update a
// requested level (target_num). The applied level (freq_num) then ramps toward
// the target one step at a time. Two rules limit each step:
//   - a minimum dwell time must pass after the previous step, and
//   - the step commits only on a falling slow_clk boundary.
// Because of the second rule, every emitted slow_clk period is complete.
//
// Handshake: a command transfers on a CLK_50 edge where cmd_valid && cmd_ready.
// cmd_ready is high only while the scheduler is settled: the FSM is idle and
// freq_num == target_num. A command that is not accepted is simply not taken.
// The requester may hold cmd_valid high until it sees cmd_ready.
//
// Ports
//   CLK_50      in   system clock
//   reset       in   synchronous, active-low reset
//   up_req      in   one-cycle pulse, target +1 (saturating)
//   dn_req      in   one-cycle pulse, target -1 (saturating)
//   cmd_valid   in   external set-point valid
//   cmd_level   in   external set-point level (clamped to NUM_LEVELS-1)
//   cmd_ready   out  command accepted this cycle when cmd_valid is high
//   target_num  out  requested level
//   freq_num    out  applied (committed) level
//   slow_clk    out  throttled clock, 50% duty, held 0 at level 0
//   tick        out  one-cycle pulse in the first cycle slow_clk reads 1
//   busy        out  ramp in progress
//   state_dbg   out  FSM state (0 idle, 1 dwell, 2 wait for edge)
// -----------------------------------------------------------------------------
module throttle_rate_sched #(
  parameter int NUM_LEVELS = 6,
  parameter int LEVEL_W    = 3,
  parameter int BASE_HALF  = 3_125_000,
  parameter int STEP_DWELL = 25_000_000,
  parameter int CNT_W      = 32
) (
  input  logic               CLK_50,
  input  logic               reset,
  input  logic               up_req,
  input  logic               dn_req,
  input  logic               cmd_valid,
  input  logic [LEVEL_W-1:0] cmd_level,
  output logic               cmd_ready,
  output logic [LEVEL_W-1:0] target_num,
  output logic [LEVEL_W-1:0] freq_num,
  output logic               slow_clk,
  output logic               tick,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DWELL     = 2'd1,
    WAIT_EDGE = 2'd2
  } state_t;

  localparam logic [LEVEL_W-1:0] MAX_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);
  localparam logic [CNT_W-1:0]   DWELL_MAX = CNT_W'(STEP_DWELL);
  localparam logic [CNT_W-1:0]   HALF_TOP  = CNT_W'(BASE_HALF);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  state_t             state;
  logic [CNT_W-1:0]   half_cnt;
  logic [CNT_W-1:0]   dwell_cnt;
  logic [CNT_W-1:0]   half_last;
  logic [LEVEL_W-1:0] cmd_clamped;
  logic [LEVEL_W-1:0] next_target;
  logic [LEVEL_W-1:0] step_level;
  logic               cmd_accept;
  logic               dwell_done;
  logic               level_match;
  logic               at_boundary;
  logic               commit;

  assign busy      = (state != IDLE) || (freq_num != target_num);
  assign cmd_ready = !busy;
  assign state_dbg = state;

  always_comb begin
    // The half period doubles for each level below the top one.
    // At level 0 this value is not used, because the counter is held there.
    half_last   = (HALF_TOP << (MAX_LEVEL - freq_num)) - CNT_ONE;
    dwell_done  = (dwell_cnt == DWELL_MAX);
    level_match = (freq_num == target_num);

    // Level 0 has no running clock, so it can leave at any time.
    // Otherwise the last cycle of the high phase is the falling boundary.
    at_boundary = (freq_num == '0) || (slow_clk && (half_cnt == half_last));
    commit      = (state == WAIT_EDGE) && !level_match && at_boundary;

    // The direction is taken from the target at the commit itself.
    // A target that was redirected mid-ramp is therefore followed.
    step_level  = (target_num > freq_num) ? (freq_num + LEVEL_ONE)
                                          : (freq_num - LEVEL_ONE);

    cmd_clamped = (cmd_level > MAX_LEVEL) ? MAX_LEVEL : cmd_level;
    cmd_accept  = cmd_valid && cmd_ready;

    // A command wins over the buttons. Both buttons pressed together cancel.
    next_target = target_num;
    if (cmd_accept) begin
      next_target = cmd_clamped;
    end else if (up_req && !dn_req) begin
      if (target_num != MAX_LEVEL) begin
        next_target = target_num + LEVEL_ONE;
      end
    end else if (dn_req && !up_req) begin
      if (target_num != '0) begin
        next_target = target_num - LEVEL_ONE;
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    if (!reset) begin
      state      <= IDLE;
      target_num <= '0;
      freq_num   <= '0;
      half_cnt   <= '0;
      slow_clk   <= 1'b0;
      tick       <= 1'b0;
      // The dwell counter starts full, so the first step needs no dwell.
      dwell_cnt  <= DWELL_MAX;
    end else begin
      target_num <= next_target;
      tick       <= 1'b0;

      // Half-period counter and slow clock.
      // A commit restarts the low phase at the new level.
      if (commit) begin
        freq_num <= step_level;
        half_cnt <= '0;
        slow_clk <= 1'b0;
      end else if (freq_num == '0) begin
        half_cnt <= '0;
        slow_clk <= 1'b0;
      end else if (half_cnt == half_last) begin
        half_cnt <= '0;
        slow_clk <= !slow_clk;
        tick     <= !slow_clk;
      end else begin
        half_cnt <= half_cnt + CNT_ONE;
      end

      // Dwell counter: counts from the last commit and saturates.
      if (commit) begin
        dwell_cnt <= '0;
      end else if (!dwell_done) begin
        dwell_cnt <= dwell_cnt + CNT_ONE;
      end

      // Ramp sequencer
      case (state)
        IDLE: begin
          if (!level_match) begin
            state <= dwell_done ? WAIT_EDGE : DWELL;
          end
        end
        DWELL: begin
          if (level_match) begin
            state <= IDLE;
          end else if (dwell_done) begin
            state <= WAIT_EDGE;
          end
        end
        WAIT_EDGE: begin
          // The ramp may have become unnecessary, or the step committed.
          // In both cases the sequencer returns to IDLE.
          if (level_match || at_boundary) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_throttle_rate_sched.sv
// -----------------------------------------------------------------------------
// tb_throttle_rate_sched
//
// Bench for throttle_rate_sched with BASE_HALF=4, STEP_DWELL=10, NUM_LEVELS=6.
//
// The reference model is built from the behavioural rules. Its state is:
//   - the requested and applied levels,
//   - the number of cycles since the last commit (age), and
//   - the ramp phase.
// slow_clk and tick are derived from age with division and modulo.
// After every edge the model pushes the expected output vector.
// A monitor on the falling edge pops that vector and compares it with the DUT.
// A few directed timing measurements add constant-based checks.
// -----------------------------------------------------------------------------
module tb_throttle_rate_sched;

  localparam int NL = 6;
  localparam int LW = 3;
  localparam int BH = 4;
  localparam int SD = 10;
  localparam int CW = 32;
  localparam int OUT_W = LW + LW + 1 + 1 + 1 + 1 + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          up = 1'b0;
  logic          dn = 1'b0;
  logic          cv = 1'b0;
  logic [LW-1:0] cl = '0;

  logic          cmd_ready;
  logic [LW-1:0] target_num;
  logic [LW-1:0] freq_num;
  logic          slow_clk;
  logic          tick;
  logic          busy;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_q[$];

  // Model state. Phase: 0 settled, 1 dwelling, 2 waiting for a boundary.
  int m_tgt = 0;
  int m_frq = 0;
  int m_age = SD;
  int m_ph  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  throttle_rate_sched #(
    .NUM_LEVELS (NL),
    .LEVEL_W    (LW),
    .BASE_HALF  (BH),
    .STEP_DWELL (SD),
    .CNT_W      (CW)
  ) dut (
    .CLK_50     (clk),
    .reset      (rst_n),
    .up_req     (up),
    .dn_req     (dn),
    .cmd_valid  (cv),
    .cmd_level  (cl),
    .cmd_ready  (cmd_ready),
    .target_num (target_num),
    .freq_num   (freq_num),
    .slow_clk   (slow_clk),
    .tick       (tick),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- reference model ----------------
  function automatic int half_of(input int k);
    return (k > 0) ? (BH << (NL - 1 - k)) : 1;
  endfunction

  function automatic logic [OUT_W-1:0] model_outputs();
    int  h;
    logic s;
    logic t;
    logic b;
    h = half_of(m_frq);
    s = (m_frq > 0) && (((m_age / h) % 2) == 1);
    t = s && ((m_age % h) == 0);
    b = (m_ph != 0) || (m_frq != m_tgt);
    return {LW'(m_tgt), LW'(m_frq), s, t, b, !b, 2'(m_ph)};
  endfunction

  always @(posedge clk) begin
    int  nt;
    int  h;
    bit  settled;
    bit  done;
    bit  fall;
    bit  commit;
    if (!rst_n) begin
      m_tgt = 0;
      m_frq = 0;
      m_age = SD;
      m_ph  = 0;
    end else begin
      settled = (m_ph == 0) && (m_frq == m_tgt);
      if (cv && settled)      nt = (int'(cl) > NL - 1) ? NL - 1 : int'(cl);
      else if (up && !dn)     nt = (m_tgt < NL - 1) ? m_tgt + 1 : m_tgt;
      else if (dn && !up)     nt = (m_tgt > 0) ? m_tgt - 1 : 0;
      else                    nt = m_tgt;

      done   = (m_age >= SD);
      h      = half_of(m_frq);
      fall   = (m_frq == 0) || (((m_age + 1) % (2 * h)) == 0);
      commit = 1'b0;
      if (m_frq == m_tgt) begin
        m_ph = 0;
      end else if (m_ph == 0) begin
        m_ph = done ? 2 : 1;
      end else if (m_ph == 1) begin
        if (done) m_ph = 2;
      end else if (fall) begin
        commit = 1'b1;
        m_ph   = 0;
      end

      if (commit) begin
        m_frq = (m_tgt > m_frq) ? m_frq + 1 : m_frq - 1;
        m_age = 0;
      end else begin
        m_age = m_age + 1;
      end
      m_tgt = nt;
    end
    exp_q.push_back(model_outputs());
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [OUT_W-1:0] e;
    logic [OUT_W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {target_num, freq_num, slow_clk, tick, busy, cmd_ready, state_dbg};
      checks++;
      if (a !== e) begin
        errors++;
        if (errors <= 20)
          $display("FAIL outputs t=%0t {tgt,frq,slow,tick,busy,rdy,st} actual=%b required=%b",
                   $time, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic u, input logic d,
                       input logic v, input logic [LW-1:0] l);
    @(negedge clk);
    rst_n = r;
    up    = u;
    dn    = d;
    cv    = v;
    cl    = l;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_val(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic wait_freq(input int lvl, input int budget);
    int n;
    n = 0;
    while (int'(freq_num) != lvl && n < budget) begin
      idle(1);
      n++;
    end
    check_val("wait_freq", int'(freq_num), lvl);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;

    // Reset held with up_req pulsing.
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(1);
    check_val("reset_freq", int'(freq_num), 0);
    check_val("reset_ready", int'(cmd_ready), 1);

    // First step from level 0. Rising edge 64 cycles after the commit.
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    wait_freq(1, 10);
    n = 0;
    while (!slow_clk && n < 300) begin idle(1); n++; end
    check_val("first_rise", n, 64);
    n = 0;
    while (slow_clk && n < 300) begin idle(1); n++; end
    while (!slow_clk && n < 300) begin idle(1); n++; end
    check_val("period_l1", n, 128);

    // Ramp 1 -> 5. A second command during the ramp must be refused.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
    idle(3);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
    wait_freq(5, 1000);
    idle(3);

    // Saturation, conflict and clamp.
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    idle(2);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    wait_freq(0, 2000);
    idle(3);
    drive(1'b1, 1'b0, 1'b1, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd7);
    idle(1);
    check_val("clamp_target", int'(target_num), 5);
    wait_freq(5, 1000);
    idle(3);

    // Command and up_req in the same cycle from level 0.
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
    idle(1);
    check_val("cmd_over_button", int'(target_num), 2);
    wait_freq(2, 500);
    idle(2);

    // Reset during WAIT_EDGE with slow_clk high at level 3.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
    wait_freq(3, 500);
    idle(2);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
    n = 0;
    while (!(state_dbg == 2'd2 && slow_clk && freq_num == 3'd3) && n < 500) begin
      idle(1);
      n++;
    end
    check_val("reach_wait_high", int'(slow_clk), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(1);
    check_val("mid_reset_freq", int'(freq_num), 0);
    check_val("mid_reset_state", int'(state_dbg), 0);
    check_val("mid_reset_slow", int'(slow_clk), 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 999) != 0),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 29) == 0),
            LW'($urandom_range(0, 7)));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
